// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : ssd_scan_driver
// Brief    : Time-multiplexed driver for a 4-digit common-anode 7-segment
//            display. A prescaler divides the clock into digit slots; a
//            scan FSM rotates through the digits. A one-cycle blank at the
//            start of every slot prevents ghosting. The four digit codes are
//            snapshotted once per frame, which prevents tearing and provides
//            a freeze (lap) hold.
// Options  : define LEADING_ZERO_BLANK_EN to suppress leading zeros on
//            digits 1..3. Digit 4 is always shown.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_scan_driver #(
  parameter int c_REFRESH_DIV = 100000
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic [3:0] i_Digit_1_val,
  input  logic [3:0] i_Digit_2_val,
  input  logic [3:0] i_Digit_3_val,
  input  logic [3:0] i_Digit_4_val,
  input  logic       i_Freeze,
  input  logic [3:0] i_DP_Sel,
  output logic [3:0] o_Anode,
  output logic [6:0] o_Segment,
  output logic       o_DP
);

  localparam int                 c_CNT_W    = $clog2(c_REFRESH_DIV);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_REFRESH_DIV - 1);
  localparam logic [6:0]         c_SEG_OFF  = 7'b1111111;

  // The state encoding doubles as the index of the active digit (0 = digit 1).
  typedef enum logic [1:0] {
    S_D1 = 2'd0,
    S_D2 = 2'd1,
    S_D3 = 2'd2,
    S_D4 = 2'd3
  } state_t;

  logic [c_CNT_W-1:0] r_Refresh_cnt;
  logic               r_Blank;
  state_t             state_q;
  logic [3:0]         shadow_q [4];

  logic               tick_d;
  logic [1:0]         sel_d;
  logic [3:0]         anode_d;
  logic [6:0]         seg_d;
  logic               dp_d;
  logic [3:0]         lead_zero_d;

  // Hex to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  // Slot tick and next display values for the currently active digit.
  always_comb begin
    tick_d  = (r_Refresh_cnt == c_CNT_LAST);
    sel_d   = state_q;
    anode_d = ~(4'b1000 >> sel_d);
    dp_d    = ~i_DP_Sel[2'd3 - sel_d];
    // lead_zero_d[n]: digit n and every digit to its left hold zero.
    // Bit 3 (digit 4) is never set, so the last digit always shows.
    lead_zero_d[0] = (shadow_q[0] == 4'h0);
    lead_zero_d[1] = lead_zero_d[0] && (shadow_q[1] == 4'h0);
    lead_zero_d[2] = lead_zero_d[1] && (shadow_q[2] == 4'h0);
    lead_zero_d[3] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    seg_d = lead_zero_d[sel_d] ? c_SEG_OFF : seg_decode(shadow_q[sel_d]);
`else
    seg_d = seg_decode(shadow_q[sel_d]);
`endif
  end

  // Prescaler: counts 0..c_REFRESH_DIV-1 and wraps; the terminal count is the slot tick.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_Refresh_cnt <= '0;
    end else if (tick_d) begin
      r_Refresh_cnt <= '0;
    end else begin
      r_Refresh_cnt <= r_Refresh_cnt + 1'b1;
    end
  end

  // Scan FSM with frame snapshot, blanking gap and registered outputs.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q   <= S_D1;
      r_Blank   <= 1'b1;
      shadow_q  <= '{default: 4'h0};
      o_Anode   <= 4'b1111;
      o_Segment <= c_SEG_OFF;
      o_DP      <= 1'b1;
    end else begin
      // Blank for exactly the cycle after every tick edge.
      r_Blank <= tick_d;

      if (tick_d) begin
        case (state_q)
          S_D1:    state_q <= S_D2;
          S_D2:    state_q <= S_D3;
          S_D3:    state_q <= S_D4;
          default: state_q <= S_D1;
        endcase
        // Frame boundary: the only point where digits and freeze are sampled.
        if (state_q == S_D4 && !i_Freeze) begin
          shadow_q[0] <= i_Digit_1_val;
          shadow_q[1] <= i_Digit_2_val;
          shadow_q[2] <= i_Digit_3_val;
          shadow_q[3] <= i_Digit_4_val;
        end
      end

      if (r_Blank) begin
        o_Anode   <= 4'b1111;
        o_Segment <= c_SEG_OFF;
        o_DP      <= 1'b1;
      end else begin
        o_Anode   <= anode_d;
        o_Segment <= seg_d;
        o_DP      <= dp_d;
      end
    end
  end

endmodule
`default_nettype wire
